// File: rtl/mem_port.sv
// Memory access unit: one registered read/write at a time, byte-lane steering,
// core stall while busy. Optional ready-wait abort enabled by MEM_PORT_TIMEOUT_EN.
module mem_port #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] addr_in,
  input  logic [15:0] wdata_in,
  input  logic        bytemode,
  input  logic        rd_req,
  input  logic        wr_req,
  output logic        stall,
  output logic [15:0] rdata_out,
  output logic        rdata_valid,
  output logic        bus_err,
  output logic [14:0] mem_addr,
  output logic [15:0] mem_wdata,
  output logic [1:0]  mem_be,
  output logic        mem_en,
  output logic        mem_we,
  input  logic [15:0] mem_rdata,
  input  logic        mem_ready
);

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_READ  = 2'd1;
  localparam logic [1:0] ST_WRITE = 2'd2;

  logic [1:0] state_reg;
  logic       byte_reg;
  logic       odd_reg;
  logic       done;
  logic       abort;

  if (TIMEOUT < 1 || TIMEOUT > 255) begin : g_timeout_range
    $error("mem_port: TIMEOUT must be in 1..255");
  end

  function automatic logic [15:0] fmt_rdata(input logic [15:0] d, input logic b, input logic odd);
    if (!b)
      return d;
    else if (odd)
      return {8'h00, d[15:8]};
    else
      return {8'h00, d[7:0]};
  endfunction

  assign done  = mem_en && mem_ready;
  assign stall = (state_reg != ST_IDLE);

`ifdef MEM_PORT_TIMEOUT_EN
  logic [7:0] cnt_reg;

  // Abort on the wait cycle that would bring the count up to TIMEOUT; a ready wins.
  assign abort = mem_en && !mem_ready && (cnt_reg == 8'(TIMEOUT - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_reg <= 8'd0;
      bus_err <= 1'b0;
    end else begin
      bus_err <= abort;
      if (state_reg == ST_IDLE)
        cnt_reg <= 8'd0;
      else if (mem_en && !mem_ready)
        cnt_reg <= cnt_reg + 8'd1;
    end
  end
`else
  assign abort   = 1'b0;
  assign bus_err = 1'b0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg   <= ST_IDLE;
      byte_reg    <= 1'b0;
      odd_reg     <= 1'b0;
      rdata_out   <= 16'h0000;
      rdata_valid <= 1'b0;
      mem_addr    <= 15'h0000;
      mem_wdata   <= 16'h0000;
      mem_be      <= 2'b00;
      mem_en      <= 1'b0;
      mem_we      <= 1'b0;
    end else begin
      rdata_valid <= 1'b0;
      case (state_reg)
        ST_IDLE: begin
          if (wr_req || rd_req) begin
            state_reg <= wr_req ? ST_WRITE : ST_READ;
            mem_en    <= 1'b1;
            mem_we    <= wr_req;
            mem_addr  <= addr_in[15:1];
            byte_reg  <= bytemode;
            odd_reg   <= addr_in[0];
            if (bytemode) begin
              mem_be    <= addr_in[0] ? 2'b10 : 2'b01;
              mem_wdata <= {wdata_in[7:0], wdata_in[7:0]};
            end else begin
              mem_be    <= 2'b11;
              mem_wdata <= wdata_in;
            end
          end
        end
        default: begin
          if (done || abort) begin
            state_reg <= ST_IDLE;
            mem_en    <= 1'b0;
            mem_we    <= 1'b0;
            if (state_reg == ST_READ) begin
              rdata_out   <= fmt_rdata(done ? mem_rdata : 16'h3FFF, byte_reg, odd_reg);
              rdata_valid <= 1'b1;
            end
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_port.sv
// Directed table-driven bench for mem_port, with hand sequences for reset
// mid-access and (when MEM_PORT_TIMEOUT_EN is defined) the timeout abort.
module tb_mem_port;

`ifdef MEM_PORT_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic [15:0] addr_in, wdata_in, mem_rdata;
  logic        bytemode, rd_req, wr_req, mem_ready;
  logic        stall, rdata_valid, bus_err, mem_en, mem_we;
  logic [15:0] rdata_out, mem_wdata;
  logic [14:0] mem_addr;
  logic [1:0]  mem_be;

  int checks = 0;
  int errors = 0;

  mem_port #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .addr_in(addr_in), .wdata_in(wdata_in),
    .bytemode(bytemode), .rd_req(rd_req), .wr_req(wr_req), .stall(stall),
    .rdata_out(rdata_out), .rdata_valid(rdata_valid), .bus_err(bus_err),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_be(mem_be),
    .mem_en(mem_en), .mem_we(mem_we), .mem_rdata(mem_rdata), .mem_ready(mem_ready)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        wr, rd, bmode;
    logic [15:0] addr, wdata, mrdata;
    int          delay;
    logic [14:0] e_maddr;
    logic [1:0]  e_be;
    logic [15:0] e_wdata;
    logic        e_we;
    logic [15:0] e_rdata;
    logic        e_valid;
  } vec_t;

  vec_t vecs[6];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h required=%h", name, act, exp);
    end
  endtask

  // Starts at a negedge with the DUT idle; returns at the negedge of the first idle cycle.
  task automatic run_vec(input vec_t v, input int idx);
    int stall_cnt;
    int waited;
    wr_req = v.wr; rd_req = v.rd; bytemode = v.bmode;
    addr_in = v.addr; wdata_in = v.wdata; mem_rdata = v.mrdata; mem_ready = 1'b0;
    @(negedge clk);
    wr_req = 1'b0; rd_req = 1'b0; addr_in = 16'hFFFF; wdata_in = 16'h5555; bytemode = ~v.bmode;
    chk($sformatf("v%0d stall", idx), stall, 1);
    chk($sformatf("v%0d mem_en", idx), mem_en, 1);
    chk($sformatf("v%0d mem_we", idx), mem_we, v.e_we);
    chk($sformatf("v%0d mem_addr", idx), mem_addr, v.e_maddr);
    chk($sformatf("v%0d mem_be", idx), mem_be, v.e_be);
    chk($sformatf("v%0d mem_wdata", idx), mem_wdata, v.e_wdata);
    chk($sformatf("v%0d valid_low", idx), rdata_valid, 0);
    stall_cnt = 1;
    waited = 0;
    mem_ready = (v.delay == 0);
    while (stall_cnt <= 40) begin
      @(negedge clk);
      if (!stall) break;
      stall_cnt++;
      waited++;
      chk($sformatf("v%0d hold_addr", idx), {mem_en, mem_addr}, {1'b1, v.e_maddr});
      mem_ready = (waited >= v.delay);
    end
    mem_ready = 1'b0;
    chk($sformatf("v%0d stall_cycles", idx), stall_cnt, v.delay + 1);
    chk($sformatf("v%0d en_off", idx), mem_en, 0);
    chk($sformatf("v%0d rdata_valid", idx), rdata_valid, v.e_valid);
    chk($sformatf("v%0d rdata_out", idx), rdata_out, v.e_rdata);
    chk($sformatf("v%0d bus_err", idx), bus_err, 0);
    $display("vec %0d addr=%h stall_cycles=%0d rdata_out=%h valid=%0d", idx, v.addr, stall_cnt, rdata_out, rdata_valid);
  endtask

  initial begin
    int cyc;
    //          wr    rd    byte  addr      wdata     mrdata    d  maddr     be     mwdata    we    rdata     valid
    vecs[0] = '{1'b0, 1'b1, 1'b0, 16'h0006, 16'h0000, 16'h4315, 0, 15'h0003, 2'b11, 16'h0000, 1'b0, 16'h4315, 1'b1};
    vecs[1] = '{1'b0, 1'b1, 1'b1, 16'h0009, 16'h0000, 16'hA55A, 3, 15'h0004, 2'b10, 16'h0000, 1'b0, 16'h00A5, 1'b1};
    vecs[2] = '{1'b1, 1'b0, 1'b1, 16'h0010, 16'h12FF, 16'h1234, 0, 15'h0008, 2'b01, 16'hFFFF, 1'b1, 16'h00A5, 1'b0};
    vecs[3] = '{1'b1, 1'b1, 1'b0, 16'h0020, 16'hBEEF, 16'h1111, 2, 15'h0010, 2'b11, 16'hBEEF, 1'b1, 16'h00A5, 1'b0};
    vecs[4] = '{1'b0, 1'b1, 1'b1, 16'h0102, 16'h0000, 16'h77C3, 1, 15'h0081, 2'b01, 16'h0000, 1'b0, 16'h00C3, 1'b1};
    vecs[5] = '{1'b0, 1'b1, 1'b0, 16'h0103, 16'h0000, 16'h9ABC, 0, 15'h0081, 2'b11, 16'h0000, 1'b0, 16'h9ABC, 1'b1};

    rst_n = 1'b0; addr_in = 16'h0; wdata_in = 16'h0; bytemode = 1'b0;
    rd_req = 1'b0; wr_req = 1'b0; mem_rdata = 16'h0; mem_ready = 1'b0;
    #12;
    chk("rst stall", stall, 0);
    chk("rst mem_en", mem_en, 0);
    chk("rst mem_we", mem_we, 0);
    chk("rst rdata_valid", rdata_valid, 0);
    chk("rst bus_err", bus_err, 0);
    chk("rst rdata_out", rdata_out, 0);
    chk("rst mem_addr", mem_addr, 0);
    chk("rst mem_wdata", mem_wdata, 0);
    chk("rst mem_be", mem_be, 0);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Issued back to back: each next request is presented in the rdata_valid cycle.
    for (int i = 0; i < 6; i++) run_vec(vecs[i], i);

    // Asynchronous reset while a read waits for ready.
    rd_req = 1'b1; addr_in = 16'h0040; bytemode = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    @(negedge clk);
    chk("pre_rst stall", stall, 1);
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst mem_en", mem_en, 0);
    chk("mid_rst stall", stall, 0);
    chk("mid_rst rdata_out", rdata_out, 0);
    chk("mid_rst mem_be", mem_be, 0);
    $display("reset mid-read: mem_en=%0d stall=%0d rdata_out=%h", mem_en, stall, rdata_out);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_vec(vecs[0], 6);

`ifdef MEM_PORT_TIMEOUT_EN
    // Word read with ready stuck low: abort after TIMEOUT wait cycles.
    rd_req = 1'b1; addr_in = 16'h0030; bytemode = 1'b0; mem_ready = 1'b0;
    @(negedge clk);
    rd_req = 1'b0;
    cyc = 1;
    while (stall && cyc < 40) begin
      @(negedge clk);
      if (stall) cyc++;
    end
    chk("to stall_cycles", cyc, TO);
    chk("to stall", stall, 0);
    chk("to bus_err", bus_err, 1);
    chk("to rdata_valid", rdata_valid, 1);
    chk("to rdata_out", rdata_out, 16'h3FFF);
    $display("timeout word read: cycles=%0d bus_err=%0d rdata_out=%h", cyc, bus_err, rdata_out);
    @(negedge clk);
    chk("to bus_err_pulse", bus_err, 0);
    chk("to stall_after", stall, 0);
`else
    cyc = 0;
    chk("no_to bus_err", bus_err, 0);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
